vme_cmd_sequencer: RTL and testbench

//  Synthesizable successor to the simulation VME command player. Runs a command program held in an

---
 rtl/vme_seq_pkg.sv | 36 +++
 rtl/vme_seq_ram.sv | 30 +++
 rtl/vme_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_vme_cmd_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_seq_pkg.sv
// Shared definitions for the VME command sequencer: op codes, FSM states, command-word bits.
package vme_seq_pkg;

   typedef enum logic [1:0] {
      OP_END      = 2'b00,
      OP_WRITE    = 2'b01,
      OP_READ     = 2'b10,
      OP_READ_CHK = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WAIT_RDY,
      S_ISSUE,
      S_WAIT_ACK,
      S_LOG
   } state_t;

   localparam logic [31:0] CMD_RD_BIT = 32'h0200_0000;
   localparam logic [31:0] CMD_WR_BIT = 32'h0100_0000;

   function automatic logic [31:0] cmd_word(input logic [31:0] mask, input op_t op,
                                            input logic [15:0] instr);
      logic [31:0] w;
      w = mask | {16'h0000, instr};
      if (op == OP_WRITE) begin
         w = w | CMD_WR_BIT;
      end else if (op != OP_END) begin
         w = w | CMD_RD_BIT;
      end
      return w;
   endfunction

endpackage

// File: rtl/vme_seq_ram.sv
// Program store: one write port, one registered read port (1-cycle latency, read enable gated).
module vme_seq_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int EW    = 34
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/vme_cmd_sequencer.sv
// Plays a RAM-held command program onto the ODMB VME command/data register interface,
// one result word per command; waits on vme_cmd_rd before issuing, times out after TMO cycles.
module vme_cmd_sequencer
   import vme_seq_pkg::*;
#(
   parameter int          DEPTH = 256,
   parameter int          AW    = 8,
   parameter int          DW    = 16,
   parameter logic [31:0] MASK  = 32'h00a80000,
   parameter int          TMO   = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [2+16+DW-1:0] prog_data,
   input  logic              run,
   input  logic              loop_en,
   input  logic              abort,
   output logic              busy,
   input  logic              vme_cmd_rd,
   output logic              start,
   output logic [31:0]       vme_cmd_reg,
   output logic [31:0]       vme_dat_reg_in,
   input  logic              vme_dat_wr,
   input  logic [31:0]       vme_dat_reg_out,
   output logic              res_valid,
   output logic [15:0]       res_instr,
   output logic [DW-1:0]     res_data,
   output logic              res_err,
   output logic [15:0]       err_cnt
);

   localparam int EW = 2 + 16 + DW;
   localparam int CW = $clog2(TMO + 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            abort_q, abort_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;
   logic [31:0]     cmd_q, cmd_d;
   logic [31:0]     dat_q, dat_d;
   logic            res_valid_q, res_valid_d;
   logic [15:0]     res_instr_q, res_instr_d;
   logic [DW-1:0]   res_data_q, res_data_d;
   logic            res_err_q, res_err_d;
   logic [15:0]     err_cnt_q, err_cnt_d;

   logic [EW-1:0]   ent;
   op_t             ent_op;
   logic [15:0]     ent_instr;
   logic [DW-1:0]   ent_data;
   logic [DW-1:0]   rd_dat;
   logic            abort_pend;
   logic            unused_rd_hi;

   vme_seq_ram #(.DEPTH(DEPTH), .AW(AW), .EW(EW)) u_ram (
      .clk   (clk),
      .we    (prog_we && (state_q == S_IDLE)),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (state_q == S_FETCH),
      .raddr (pc_q),
      .rdata (ent)
   );

   assign ent_op       = op_t'(ent[EW-1:EW-2]);
   assign ent_instr    = ent[EW-3:DW];
   assign ent_data     = ent[DW-1:0];
   assign rd_dat       = vme_dat_reg_out[DW-1:0];
   assign unused_rd_hi = ^vme_dat_reg_out[31:DW];
   assign abort_pend   = abort_q || abort;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      abort_d     = abort_q;
      res_valid_d = 1'b0;
      res_instr_d = res_instr_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               err_cnt_d = '0;
            end
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (ent_op == OP_END) begin
               if (loop_en && !abort_pend) begin
                  pc_d    = '0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (vme_cmd_rd) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CW'(1);
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // an ack landing on the last counted cycle still wins over the timeout
            if (vme_dat_wr || (cnt_q == CW'(TMO))) begin
               state_d     = S_LOG;
               res_valid_d = 1'b1;
               res_instr_d = ent_instr;
               res_err_d   = !vme_dat_wr || ((ent_op == OP_READ_CHK) && (rd_dat != ent_data));
               res_data_d  = (ent_op == OP_WRITE) ? ent_data : (vme_dat_wr ? rd_dat : '0);
               if (res_err_d && (err_cnt_q != 16'hFFFF)) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_LOG: begin
            pc_d    = pc_q + AW'(1);
            state_d = abort_pend ? S_IDLE : S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         abort_d = 1'b1;
      end
      if (state_d == S_IDLE) begin
         abort_d = 1'b0;
      end

      busy_d  = (state_d != S_IDLE);
      start_d = (state_d == S_ISSUE);
      if ((state_d == S_ISSUE) || (state_d == S_WAIT_ACK)) begin
         cmd_d = cmd_word(MASK, ent_op, ent_instr);
         dat_d = 32'(ent_data);
      end else begin
         cmd_d = MASK;
         dat_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         cmd_q       <= MASK;
         dat_q       <= '0;
         res_valid_q <= 1'b0;
         res_instr_q <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         cmd_q       <= cmd_d;
         dat_q       <= dat_d;
         res_valid_q <= res_valid_d;
         res_instr_q <= res_instr_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign busy           = busy_q;
   assign start          = start_q;
   assign vme_cmd_reg    = cmd_q;
   assign vme_dat_reg_in = dat_q;
   assign res_valid      = res_valid_q;
   assign res_instr      = res_instr_q;
   assign res_data       = res_data_q;
   assign res_err        = res_err_q;
   assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_vme_cmd_sequencer.sv
// Directed bench for vme_cmd_sequencer with a delayed-ack VME responder and start/result monitors.
module tb_vme_cmd_sequencer;

   localparam logic [31:0] MASK = 32'h00a80000;
   localparam int          TMO  = 1023;

   logic        clk = 1'b0, rst = 1'b1, prog_we = 1'b0, run = 1'b0, loop_en = 1'b0, abort = 1'b0;
   logic        vme_cmd_rd = 1'b0, vme_dat_wr = 1'b0;
   logic [7:0]  prog_addr = '0;
   logic [33:0] prog_data = '0;
   logic [31:0] vme_dat_reg_out = '0;
   logic        busy, start, res_valid, res_err;
   logic [31:0] vme_cmd_reg, vme_dat_reg_in;
   logic [15:0] res_instr, res_data, err_cnt;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, start_cyc = 0, valid_cyc = 0;
   int ack_cnt = 0, ack_dly = 3;
   logic ack_en = 1'b1;
   logic [15:0] rsp = '0;
   logic [31:0] cmd_log[$], dat_log[$], ri_log[$], rd_log[$], re_log[$];

   vme_cmd_sequencer dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .run(run), .loop_en(loop_en), .abort(abort), .busy(busy), .vme_cmd_rd(vme_cmd_rd),
      .start(start), .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
      .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out), .res_valid(res_valid),
      .res_instr(res_instr), .res_data(res_data), .res_err(res_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      vme_dat_wr = 1'b0;
      if (rst) ack_cnt = 0;
      if (ack_cnt > 0) begin
         ack_cnt = ack_cnt - 1;
         if (ack_cnt == 0) begin
            vme_dat_wr      = 1'b1;
            vme_dat_reg_out = {16'hDEAD, rsp};
         end
      end
      if (start && ack_en) ack_cnt = ack_dly;
   end

   always @(negedge clk) begin
      if (start) begin
         cmd_log.push_back(vme_cmd_reg);
         dat_log.push_back(vme_dat_reg_in);
         start_cyc = cyc;
      end
      if (res_valid) begin
         ri_log.push_back({16'h0, res_instr});
         rd_log.push_back({16'h0, res_data});
         re_log.push_back({31'h0, res_err});
         valid_cyc = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input logic [1:0] op, input logic [15:0] instr,
                       input logic [15:0] data);
      prog_we   = 1'b1;
      prog_addr = addr[7:0];
      prog_data = {op, instr, data};
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic clear_logs();
      cmd_log.delete(); dat_log.delete(); ri_log.delete(); rd_log.delete(); re_log.delete();
   endtask

   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int k;
      k = 0;
      while (busy && k < maxc) begin
         tick();
         k++;
      end
      check("idle_bound", {31'h0, busy}, 32'h0);
   endtask

   task automatic wait_starts(input int n, input int maxc);
      int k;
      k = 0;
      while (cmd_log.size() < n && k < maxc) begin
         tick();
         k++;
      end
      check("start_bound", cmd_log.size(), n);
   endtask

   initial begin
      int bad;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_start", {31'h0, start}, 32'h0);
      check("rst_cmd", vme_cmd_reg, MASK);
      check("rst_dat", vme_dat_reg_in, 32'h0);
      check("rst_valid", {31'h0, res_valid}, 32'h0);
      check("rst_errcnt", {16'h0, err_cnt}, 32'h0);

      // basic write / read / end
      load(0, 2'b01, 16'h4100, 16'h00AA);
      load(1, 2'b10, 16'h4200, 16'h0000);
      load(2, 2'b00, 16'h0000, 16'h0000);
      vme_cmd_rd = 1'b1; ack_en = 1'b1; ack_dly = 3; rsp = 16'h5555;
      clear_logs();
      pulse_run();
      check("t1_busy", {31'h0, busy}, 32'h1);
      wait_idle(200);
      check("t1_nstart", cmd_log.size(), 2);
      check("t1_cmd0", cmd_log[0], 32'h01a84100);
      check("t1_dat0", dat_log[0], 32'h000000AA);
      check("t1_cmd1", cmd_log[1], 32'h02a84200);
      check("t1_nres", ri_log.size(), 2);
      check("t1_ri0", ri_log[0], 32'h4100);
      check("t1_rd0", rd_log[0], 32'h00AA);
      check("t1_rd1", rd_log[1], 32'h5555);
      check("t1_re1", re_log[1], 32'h0);
      check("t1_lat", valid_cyc - start_cyc, 4);
      check("t1_cmd_idle", vme_cmd_reg, MASK);

      // read-check mismatch then match (second run also pulses abort alongside run)
      load(0, 2'b11, 16'h3000, 16'h1234);
      load(1, 2'b00, 16'h0000, 16'h0000);
      abort = 1'b1; tick(); abort = 1'b0;
      rsp = 16'h1235;
      clear_logs();
      pulse_run();
      wait_idle(200);
      check("t2_nres", ri_log.size(), 1);
      check("t2_err", re_log[0], 32'h1);
      check("t2_errcnt", {16'h0, err_cnt}, 32'h1);
      rsp = 16'h1234;
      clear_logs();
      run = 1'b1; abort = 1'b1; tick(); run = 1'b0; abort = 1'b0;
      wait_idle(200);
      check("t2_nres_b", ri_log.size(), 1);
      check("t2_ok", re_log[0], 32'h0);
      check("t2_rd", rd_log[0], 32'h1234);
      check("t2_errcnt_b", {16'h0, err_cnt}, 32'h0);

      // timeouts, with a run pulse while busy
      load(0, 2'b01, 16'h5000, 16'h0001);
      load(1, 2'b10, 16'h5001, 16'h0000);
      load(2, 2'b00, 16'h0000, 16'h0000);
      ack_en = 1'b0;
      clear_logs();
      pulse_run();
      repeat (10) tick();
      pulse_run();
      wait_idle(3000);
      check("t3_nres", ri_log.size(), 2);
      check("t3_lat", valid_cyc - start_cyc, TMO + 1);
      check("t3_err0", re_log[0], 32'h1);
      check("t3_ri1", ri_log[1], 32'h5001);
      check("t3_errcnt", {16'h0, err_cnt}, 32'h2);

      // ack exactly on the last counted cycle is a completion
      ack_en = 1'b1; ack_dly = TMO;
      clear_logs();
      pulse_run();
      wait_idle(3000);
      check("t3_edge_n", re_log.size(), 2);
      check("t3_edge_err", re_log[0], 32'h0);
      check("t3_edge_lat", valid_cyc - start_cyc, TMO + 1);

      // looping program, abort during second command
      load(0, 2'b01, 16'hA000, 16'h0001);
      load(1, 2'b01, 16'hB000, 16'h0002);
      load(2, 2'b00, 16'h0000, 16'h0000);
      ack_dly = 2; loop_en = 1'b1;
      clear_logs();
      pulse_run();
      wait_starts(4, 200);
      abort = 1'b1; tick(); abort = 1'b0;
      wait_idle(100);
      loop_en = 1'b0;
      check("t4_nstart", cmd_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] c;
         c = cmd_log[i];
         check("t4_order", {16'h0, c[15:0]}, (i % 2 == 0) ? 32'hA000 : 32'hB000);
      end
      check("t4_nres", ri_log.size(), 4);
      check("t4_last", ri_log[3], 32'hB000);

      // backpressure on vme_cmd_rd
      load(0, 2'b01, 16'h6000, 16'h0003);
      load(1, 2'b00, 16'h0000, 16'h0000);
      vme_cmd_rd = 1'b0;
      clear_logs();
      pulse_run();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (start !== 1'b0 || vme_cmd_reg !== MASK) bad++;
      end
      check("t5_hold", bad, 0);
      vme_cmd_rd = 1'b1;
      tick();
      check("t5_start", {31'h0, start}, 32'h1);
      check("t5_cmd", vme_cmd_reg, 32'h01a86000);
      wait_idle(200);

      // reset during the VME wait
      load(0, 2'b10, 16'h7000, 16'h0000);
      load(1, 2'b00, 16'h0000, 16'h0000);
      ack_en = 1'b0;
      clear_logs();
      pulse_run();
      wait_starts(1, 50);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("t6_busy", {31'h0, busy}, 32'h0);
      check("t6_cmd", vme_cmd_reg, MASK);
      rst = 1'b0;
      repeat (3) tick();
      check("t6_nores", ri_log.size(), 0);
      ack_en = 1'b1;
      clear_logs();
      pulse_run();
      wait_idle(200);
      check("t6_recmd", cmd_log[0], 32'h02a87000);
      check("t6_nres", ri_log.size(), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
